// File: rtl/vo_timing_gen.sv
// Video timing generator with two timing sets, a pause input, line and
// frame start strobes, and a configurable sync/blank output delay.
// The col/line counters are stage 0. The sync and blank outputs trail them
// by PIPE_DLY register stages.
module vo_timing_gen #(
  parameter int H_ACTIVE0 = 1920,
  parameter int H_FP0     = 88,
  parameter int H_SYNC0   = 44,
  parameter int H_BP0     = 148,
  parameter int H_POS0    = 1,
  parameter int V_ACTIVE0 = 1080,
  parameter int V_FP0     = 4,
  parameter int V_SYNC0   = 5,
  parameter int V_BP0     = 36,
  parameter int V_POS0    = 1,
  parameter int H_ACTIVE1 = 640,
  parameter int H_FP1     = 16,
  parameter int H_SYNC1   = 96,
  parameter int H_BP1     = 48,
  parameter int H_POS1    = 0,
  parameter int V_ACTIVE1 = 480,
  parameter int V_FP1     = 11,
  parameter int V_SYNC1   = 2,
  parameter int V_BP1     = 31,
  parameter int V_POS1    = 0,
  parameter int CNT_W     = 12,
  parameter int PIPE_DLY  = 1
) (
  input  logic             vo_clk,
  input  logic             vo_reset,
  input  logic             enable,
  input  logic             mode_sel,
  output logic             mode_active,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] line,
  output logic             line_start,
  output logic             frame_start,
  output logic             vo_hsync,
  output logic             vo_vsync,
  output logic             vo_blank_
);

  // Bounds are held one bit wider than the counters so that a sync pulse
  // ending exactly at 2^CNT_W can still be represented.
  localparam int BW  = CNT_W + 1;
  localparam int HT0 = H_ACTIVE0 + H_FP0 + H_SYNC0 + H_BP0;
  localparam int VT0 = V_ACTIVE0 + V_FP0 + V_SYNC0 + V_BP0;
  localparam int HT1 = H_ACTIVE1 + H_FP1 + H_SYNC1 + H_BP1;
  localparam int VT1 = V_ACTIVE1 + V_FP1 + V_SYNC1 + V_BP1;

  localparam logic HP0 = (H_POS0 != 0);
  localparam logic VP0 = (V_POS0 != 0);
  localparam logic HP1 = (H_POS1 != 0);
  localparam logic VP1 = (V_POS1 != 0);

  logic             mode_q, mode_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] line_q, line_d;

  logic [CNT_W-1:0] ht_m1, vt_m1;
  logic [BW-1:0]    h_act, hs_beg, hs_end;
  logic [BW-1:0]    v_act, vs_beg, vs_end;
  logic             hpos, vpos;

  logic             blank_p0, hs_p0, vs_p0;
  logic [PIPE_DLY-1:0] blank_q, hs_q, vs_q;

  // Select the timing set of the mode currently in use.
  always_comb begin
    ht_m1  = CNT_W'(HT0 - 1);
    vt_m1  = CNT_W'(VT0 - 1);
    h_act  = BW'(H_ACTIVE0);
    hs_beg = BW'(H_ACTIVE0 + H_FP0);
    hs_end = BW'(H_ACTIVE0 + H_FP0 + H_SYNC0);
    v_act  = BW'(V_ACTIVE0);
    vs_beg = BW'(V_ACTIVE0 + V_FP0);
    vs_end = BW'(V_ACTIVE0 + V_FP0 + V_SYNC0);
    hpos   = HP0;
    vpos   = VP0;
    if (mode_q) begin
      ht_m1  = CNT_W'(HT1 - 1);
      vt_m1  = CNT_W'(VT1 - 1);
      h_act  = BW'(H_ACTIVE1);
      hs_beg = BW'(H_ACTIVE1 + H_FP1);
      hs_end = BW'(H_ACTIVE1 + H_FP1 + H_SYNC1);
      v_act  = BW'(V_ACTIVE1);
      vs_beg = BW'(V_ACTIVE1 + V_FP1);
      vs_end = BW'(V_ACTIVE1 + V_FP1 + V_SYNC1);
      hpos   = HP1;
      vpos   = VP1;
    end
  end

  // Counter advance. The requested mode is adopted only on the frame-wrap
  // edge, so the counters are always in range for the new set.
  always_comb begin
    col_d  = col_q;
    line_d = line_q;
    mode_d = mode_q;
    if (enable) begin
      if (col_q < ht_m1) begin
        col_d = col_q + 1'b1;
      end else begin
        col_d = '0;
        if (line_q == vt_m1) begin
          line_d = '0;
          mode_d = mode_sel;
        end else begin
          line_d = line_q + 1'b1;
        end
      end
    end
  end

  // Counter and mode state.
  always_ff @(posedge vo_clk or posedge vo_reset) begin
    if (vo_reset) begin
      col_q  <= '0;
      line_q <= '0;
      mode_q <= 1'b0;
    end else begin
      col_q  <= col_d;
      line_q <= line_d;
      mode_q <= mode_d;
    end
  end

  // Stage 0: decode sync and blank from the counters using the active set.
  always_comb begin
    blank_p0 = ({1'b0, col_q} >= h_act) || ({1'b0, line_q} >= v_act);
    hs_p0    = (({1'b0, col_q} >= hs_beg) && ({1'b0, col_q} < hs_end)) ^ ~hpos;
    vs_p0    = (({1'b0, line_q} >= vs_beg) && ({1'b0, line_q} < vs_end)) ^ ~vpos;
  end

  // Output delay line. It shifts every cycle so that a pause shows up at the
  // pins as a held position, PIPE_DLY cycles later.
  always_ff @(posedge vo_clk or posedge vo_reset) begin
    if (vo_reset) begin
      blank_q <= '1;
      hs_q    <= {PIPE_DLY{~HP0}};
      vs_q    <= {PIPE_DLY{~VP0}};
    end else begin
      blank_q[0] <= blank_p0;
      hs_q[0]    <= hs_p0;
      vs_q[0]    <= vs_p0;
      for (int i = 1; i < PIPE_DLY; i++) begin
        blank_q[i] <= blank_q[i-1];
        hs_q[i]    <= hs_q[i-1];
        vs_q[i]    <= vs_q[i-1];
      end
    end
  end

  assign mode_active = mode_q;
  assign col         = col_q;
  assign line        = line_q;
  assign line_start  = enable && (col_q == '0);
  assign frame_start = enable && (col_q == '0) && (line_q == '0);
  assign vo_hsync    = hs_q[PIPE_DLY-1];
  assign vo_vsync    = vs_q[PIPE_DLY-1];
  assign vo_blank_   = ~blank_q[PIPE_DLY-1];

endmodule

// File: tb/tb_vo_timing_gen.sv
// Directed bench for vo_timing_gen using small test timing sets.
// Two instances share the stimulus: one with PIPE_DLY=1, one with PIPE_DLY=3.
module tb_vo_timing_gen;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          msel;

  logic          ma1, ls1, fs1, hs1, vs1, bl1;
  logic [CW-1:0] col1, line1;
  logic          ma3, ls3, fs3, hs3, vs3, bl3;
  logic [CW-1:0] col3, line3;

  int n_chk = 0;
  int n_err = 0;
  int k     = 0;   // clock edges since the last reset release

  always #5 clk = ~clk;

  vo_timing_gen #(
    .H_ACTIVE0(8), .H_FP0(2), .H_SYNC0(3), .H_BP0(1), .H_POS0(1),
    .V_ACTIVE0(4), .V_FP0(1), .V_SYNC0(2), .V_BP0(1), .V_POS0(1),
    .H_ACTIVE1(4), .H_FP1(1), .H_SYNC1(1), .H_BP1(2), .H_POS1(0),
    .V_ACTIVE1(2), .V_FP1(1), .V_SYNC1(1), .V_BP1(1), .V_POS1(0),
    .CNT_W(CW), .PIPE_DLY(1)
  ) dut1 (
    .vo_clk(clk), .vo_reset(rst), .enable(en), .mode_sel(msel),
    .mode_active(ma1), .col(col1), .line(line1),
    .line_start(ls1), .frame_start(fs1),
    .vo_hsync(hs1), .vo_vsync(vs1), .vo_blank_(bl1)
  );

  vo_timing_gen #(
    .H_ACTIVE0(8), .H_FP0(2), .H_SYNC0(3), .H_BP0(1), .H_POS0(1),
    .V_ACTIVE0(4), .V_FP0(1), .V_SYNC0(2), .V_BP0(1), .V_POS0(1),
    .H_ACTIVE1(4), .H_FP1(1), .H_SYNC1(1), .H_BP1(2), .H_POS1(0),
    .V_ACTIVE1(2), .V_FP1(1), .V_SYNC1(1), .V_BP1(1), .V_POS1(0),
    .CNT_W(CW), .PIPE_DLY(3)
  ) dut3 (
    .vo_clk(clk), .vo_reset(rst), .enable(en), .mode_sel(msel),
    .mode_active(ma3), .col(col3), .line(line3),
    .line_start(ls3), .frame_start(fs3),
    .vo_hsync(hs3), .vo_vsync(vs3), .vo_blank_(bl3)
  );

  typedef struct {
    int   cyc;      // edge count at which to sample (enable held high)
    int   col;
    int   line;
    logic ls;
    logic fs;
    logic hs;       // PIPE_DLY=1 outputs
    logic vs;
    logic bl;
    logic hs3;      // PIPE_DLY=3 hsync
  } vec_t;

  vec_t vt[17];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (k=%0d)", name, act, exp, k);
    end
  endtask

  // Advance one clock; sampling happens 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
    k++;
  endtask

  task automatic run_to(input int target);
    while (k < target) tick();
  endtask

  initial begin
    int cnt_hs, cnt_bl;

    // Mode 0 decode: blank_ high for col<8 and line<4, hsync for col 10..12,
    // vsync for lines 5..6; PIPE_DLY=1 shows the previous position.
    vt[0]  = '{0,   0, 0, 1, 1, 0, 0, 0, 0};
    vt[1]  = '{1,   1, 0, 0, 0, 0, 0, 1, 0};
    vt[2]  = '{8,   8, 0, 0, 0, 0, 0, 1, 0};
    vt[3]  = '{9,   9, 0, 0, 0, 0, 0, 0, 0};
    vt[4]  = '{10, 10, 0, 0, 0, 0, 0, 0, 0};
    vt[5]  = '{11, 11, 0, 0, 0, 1, 0, 0, 0};
    vt[6]  = '{12, 12, 0, 0, 0, 1, 0, 0, 0};
    vt[7]  = '{13, 13, 0, 0, 0, 1, 0, 0, 1};
    vt[8]  = '{14,  0, 1, 1, 0, 0, 0, 0, 1};
    vt[9]  = '{15,  1, 1, 0, 0, 0, 0, 1, 1};
    vt[10] = '{16,  2, 1, 0, 0, 0, 0, 1, 0};
    vt[11] = '{57,  1, 4, 0, 0, 0, 0, 0, 1};
    vt[12] = '{71,  1, 5, 0, 0, 0, 1, 0, 1};
    vt[13] = '{98,  0, 7, 1, 0, 0, 1, 0, 1};
    vt[14] = '{99,  1, 7, 0, 0, 0, 0, 0, 1};
    vt[15] = '{112, 0, 0, 1, 1, 0, 0, 0, 1};
    vt[16] = '{113, 1, 0, 0, 0, 0, 0, 1, 1};

    rst  = 1'b1;
    en   = 1'b1;
    msel = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    k   = 0;
    #1;

    // Free run in mode 0 against the vector table.
    for (int i = 0; i < 17; i++) begin
      run_to(vt[i].cyc);
      chk("col",         col1,  vt[i].col);
      chk("line",        line1, vt[i].line);
      chk("line_start",  ls1,   vt[i].ls);
      chk("frame_start", fs1,   vt[i].fs);
      chk("hsync",       hs1,   vt[i].hs);
      chk("vsync",       vs1,   vt[i].vs);
      chk("blank_",      bl1,   vt[i].bl);
      chk("hsync_dly3",  hs3,   vt[i].hs3);
      chk("mode_active", ma1,   0);
    end

    // One full line of output: 3 hsync cycles and 8 active cycles.
    cnt_hs = 0;
    cnt_bl = 0;
    repeat (14) begin
      tick();
      if (hs1) cnt_hs++;
      if (bl1) cnt_bl++;
    end
    chk("hsync_per_line", cnt_hs, 3);
    chk("blank_per_line", cnt_bl, 8);

    // Mode request mid-frame waits for the frame wrap at k=224.
    run_to(162);
    msel = 1'b1;
    run_to(223);
    chk("mode_hold", ma1, 0);
    chk("col_eof",   col1, 13);
    chk("line_eof",  line1, 7);
    tick();
    chk("mode_switch",  ma1, 1);
    chk("fs_switch",    fs1, 1);
    chk("hs_inflight",  hs1, 0);
    tick();
    chk("hs_mode1_idle", hs1, 1);
    chk("vs_mode1_idle", vs1, 1);
    chk("bl_mode1",      bl1, 1);
    run_to(230);
    chk("hs_mode1_pulse", hs1, 0);
    tick();
    chk("hs_mode1_after", hs1, 1);
    begin
      int lim;
      lim = 0;
      tick();
      while (!fs1 && lim < 200) begin
        tick();
        lim++;
      end
      chk("fs_period_mode1", k - 224, 40);
    end

    // Reset mid-frame in mode 1 with hsync high.
    run_to(267);
    chk("hs_before_rst", hs1, 1);
    rst = 1'b1;
    #1;
    chk("rst_col",    col1, 0);
    chk("rst_line",   line1, 0);
    chk("rst_mode",   ma1, 0);
    chk("rst_blank_", bl1, 0);
    chk("rst_hsync",  hs1, 0);
    chk("rst_vsync",  vs1, 0);
    chk("rst_hsync3", hs3, 0);
    chk("rst_blank3", bl3, 0);
    #1;
    msel = 1'b0;
    rst  = 1'b0;
    k    = 0;

    // Strobes follow enable combinationally at col 0.
    en = 1'b0;
    #1;
    chk("ls_en_low", ls1, 0);
    chk("fs_en_low", fs1, 0);
    en = 1'b1;
    #1;
    chk("ls_en_high", ls1, 1);
    chk("fs_en_high", fs1, 1);

    // Pause for 5 edges at col 3: col holds for 6 sampled cycles.
    run_to(3);
    chk("pause_col", col1, 3);
    en = 1'b0;
    repeat (5) begin
      tick();
      chk("pause_col", col1, 3);
    end
    en = 1'b1;
    tick();
    chk("resume_col", col1, 4);
    begin
      int lim;
      lim = 0;
      while (!fs1 && lim < 300) begin
        tick();
        lim++;
      end
      chk("fs_period_pause", k, 117);
      chk("fs_line", line1, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/vo_timing_gen.md
# vo_timing_gen

Parametrised video timing generator for the `vo_clk` domain that drives the `vo_hsync`/`vo_vsync`/`vo_blank_` pins.
- Holds two complete timing sets (mode 0 and mode 1), each with its own porches and sync polarities. The run-time mode switch takes effect only at a frame boundary.
- Adds a pause input, line/frame start strobes, and a configurable sync/blank pipeline delay so timing lines up with downstream pixel pipelines of any depth.
- Pixel generators use `col`/`line` to address their data.

## Interface
Parameters:
- `H_ACTIVE0`, default 1920: mode 0 active pixels.
- `H_FP0`, default 88: mode 0 horizontal front porch.
- `H_SYNC0`, default 44: mode 0 horizontal sync width.
- `H_BP0`, default 148: mode 0 horizontal back porch.
- `H_POS0`, default 1: mode 0 hsync polarity (1 = active-high).
- `V_ACTIVE0`, default 1080: mode 0 active lines.
- `V_FP0`, default 4: mode 0 vertical front porch.
- `V_SYNC0`, default 5: mode 0 vertical sync width.
- `V_BP0`, default 36: mode 0 vertical back porch.
- `V_POS0`, default 1: mode 0 vsync polarity (1 = active-high).
- `H_ACTIVE1`/`H_FP1`/`H_SYNC1`/`H_BP1`/`H_POS1`, defaults 640/16/96/48/0: mode 1 horizontal set.
- `V_ACTIVE1`/`V_FP1`/`V_SYNC1`/`V_BP1`/`V_POS1`, defaults 480/11/2/31/0: mode 1 vertical set.
- `CNT_W`, default 12: counter width.
  - Each mode's H total and V total must be ≤ 2^CNT_W.
- `PIPE_DLY`, default 1: register stages between the counters and the sync/blank outputs.
  - Legal range 1..4.

Ports:
- `vo_clk`, input, 1: pixel clock.
- `vo_reset`, input, 1: reset.
  - Asynchronous and active-high.
- `enable`, input, 1: when high, timing advances; when low, counters freeze.
- `mode_sel`, input, 1: requested mode.
  - Sampled only at end of frame.
- `mode_active`, output, 1: mode currently in use.
- `col`, output, CNT_W: current column counter.
- `line`, output, CNT_W: current line counter.
- `line_start`, output, 1: `enable && col==0`.
- `frame_start`, output, 1: `enable && col==0 && line==0`.
- `vo_hsync`, output, 1: horizontal sync with the active mode's polarity.
  - Delayed PIPE_DLY cycles from the counters.
- `vo_vsync`, output, 1: vertical sync with the active mode's polarity.
  - Delayed PIPE_DLY cycles from the counters.
- `vo_blank_`, output, 1: high during active video.
  - Delayed PIPE_DLY cycles from the counters.

## Operation
- Per-mode totals:
  - HT = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - VT = V_ACTIVE+V_FP+V_SYNC+V_BP.
  - All decode uses the set selected by `mode_active`.
- Counter update, when `enable`=1:
  - If `col`<HT-1, then `col`++.
  - Otherwise `col`←0, and `line` either increments or wraps to 0 when `line`==VT-1.
- When `enable`=0: `col`, `line` and `mode_active` hold.
- Stage-0 decodes, computed from the counter registers:
  - blank = (`col`≥H_ACTIVE) || (`line`≥V_ACTIVE).
  - hs = (H_ACTIVE+H_FP ≤ `col` < H_ACTIVE+H_FP+H_SYNC) ^ !H_POS.
  - vs = (V_ACTIVE+V_FP ≤ `line` < V_ACTIVE+V_FP+V_SYNC) ^ !V_POS.
- Decodes pass through a PIPE_DLY-deep shift register.
  - The shift register shifts every cycle, regardless of `enable`.
  - Its last stage drives `vo_hsync`, `vo_vsync` and `!blank`→`vo_blank_`.
- Mode switch:
  - On the edge where `enable`=1, `col`==HT-1 and `line`==VT-1, `mode_active`←`mode_sel`.
  - Counters wrap on that same edge.
  - At any other time `mode_sel` is ignored.
  - A switch therefore never leaves counters out of range for the new mode.
- Mode change in the pipeline:
  - Stages already in flight keep the polarity they were computed with.
  - Stage 0 of the first frame in the new mode uses the new set.

## Timing
- Reset values, applied immediately on `vo_reset` assertion:
  - `col`=0, `line`=0, `mode_active`=0.
  - Every pipeline stage: blank=1, hs=!H_POS0, vs=!V_POS0.
  - Therefore `vo_blank_`=0, `vo_hsync`=!H_POS0, `vo_vsync`=!V_POS0.
- Reset asserted mid-frame aborts the frame. After release the first cycle is `col`=0, `line`=0 in mode 0.
- Latency:
  - `col`/`line`/`line_start`/`frame_start` are stage 0.
  - Sync/blank outputs lag stage 0 by exactly PIPE_DLY cycles.
- Strobes are combinational from registers and `enable`. With `enable` held low at `col`==0, they drop to 0 and re-assert when `enable` returns.
- Pause: `enable` low for N cycles stretches the current pixel by N cycles. The outputs then show that frozen position for N cycles, PIPE_DLY later.

## Test plan
Test timing sets:
- Mode 0: H 8/2/3/1 (HT=14), V 4/1/2/1 (VT=8), H_POS0=V_POS0=1. Frame = 112 cycles.
- Mode 1: H 4/1/1/2 (HT=8), V 2/1/1/1 (VT=5), H_POS1=V_POS1=0. Frame = 40 cycles.
- CNT_W=4.

Scenarios:
- Free run, PIPE_DLY=1, mode 0 → `vo_hsync`=1 for exactly 3 cycles per 14, rising 1 cycle after `col`==10; `vo_blank_`=1 for 8 cycles per line on lines 0–3 only; `vo_vsync`=1 during lines 5–6.
- Strobes → `line_start` every 14 cycles; `frame_start` every 112 cycles, coincident with `line`==0.
- `mode_sel`=1 raised at cycle 50 of a frame → `mode_active` stays 0 until the wrap at cycle 112, then `frame_start` period = 40, and `vo_hsync` idles high with 1-cycle low pulses.
- `enable`=0 for 5 cycles while `col`==3 → `col` holds at 3 for 6 cycles; the next `frame_start` arrives 117 cycles after the previous one.
- `vo_reset` pulsed while `vo_hsync`=1 in mode 1 → same cycle: `col`=`line`=0, `mode_active`=0, `vo_blank_`=0, `vo_hsync`=0, `vo_vsync`=0.
- PIPE_DLY=3, mode 0 → `vo_hsync` rises exactly 3 cycles after `col`==10 and falls 3 cycles after `col`==13.
